radio_packet_rx: RTL and testbench
==================================

Name: radio_packet_rx

Overview:
- Receiving end of the node radio serial link, used in the base-station/sink that collects node transmissions.
- Deserialises the Rx line, frames packets as SYNC, LEN, payload, CHK, and verifies the checksum.
- Buffers one payload and streams it to the host over a valid/ready handshake.
- Keeps saturating good-packet and bad-packet counters for link diagnostics.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be even and ≥4.
- MAX_LEN, 16: maximum payload bytes; sets buffer depth.
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_BITS, 20: idle bit-times allowed between bytes inside a packet.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  receiver enable; low holds the block idle
- Rx  in  1  serial line; idle high; asynchronous to clk
- out_data  out  8  payload byte
- out_valid  out  1  out_data is valid
- out_last  out  1  final payload byte of the packet
- out_ready  in  1  host accepts the byte
- busy  out  1  packet reception or delivery in progress
- pkt_ok_count  out  8  good packets, saturating at 255
- pkt_err_count  out  8  rejected packets, saturating at 255

Behaviour:
- Reset (rst_n low, asynchronous):
  - State HUNT; all outputs 0.
  - Synchroniser flops preset to 1.
  - Counters cleared.
- Rx synchronisation: 2-flop synchroniser. Bit logic sees only the synchronised value, so the line is 2 cycles late.
- Byte receiver (sub-module):
  - A falling edge on synchronised Rx while byte-idle starts a byte.
  - At CLKS_PER_BIT/2, Rx is re-checked. If high, the start was a glitch: return to idle with no error.
  - 8 data bits are then sampled every CLKS_PER_BIT, LSB first.
  - The stop bit is sampled one CLKS_PER_BIT later.
  - Stop bit = 1: byte_valid pulses 1 cycle, at the stop-sample cycle.
  - Stop bit = 0: frame_err pulses 1 cycle.
- Packet FSM:
  - HUNT:
    - A byte equal to SYNC_BYTE goes to LEN; any other byte is ignored.
    - frame_err in HUNT is ignored; no count.
  - LEN:
    - A byte in 1..MAX_LEN is stored as len; chk := byte; index := 0; go to PAYLOAD.
    - 0 or >MAX_LEN is an error.
  - PAYLOAD:
    - Each byte is written to buf[index]; chk ^= byte; index++.
    - When index reaches len, go to CHECK.
  - CHECK:
    - Byte == chk: pkt_ok_count++ and go to DELIVER.
    - Otherwise error.
  - DELIVER:
    - out_valid = 1, out_data = buf[rd_idx], out_last = (rd_idx == len-1).
    - On out_valid & out_ready, rd_idx++.
    - Accepting the last byte returns to HUNT on the next cycle.
    - Data is held stable while out_ready is low.
  - Error (from LEN, PAYLOAD or CHECK, including frame_err and timeout): pkt_err_count++ and return to HUNT next cycle. No partial payload is ever presented.
- Timeout:
  - In LEN, PAYLOAD or CHECK, a counter counts cycles with the byte receiver idle.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT is an error. The counter resets on every byte start.
- Overrun: bytes completing during DELIVER are discarded and nothing is counted. A SYNC byte arriving during DELIVER is not honoured.
- Counters saturate at 255; an increment at 255 leaves 255.
- busy = 1 in LEN, PAYLOAD, CHECK or DELIVER, or when the byte receiver is active outside HUNT.
- enable low:
  - Synchronous forced return to HUNT; the byte receiver is held idle.
  - out_valid drops next cycle and the buffered packet is discarded.
  - Counters are retained.
  - Dropping enable mid-packet does not count as an error.
- Simultaneous events: byte_valid and timeout expiry cannot coincide, because timeout counts only while idle. Byte completion in the same cycle as enable going low means enable wins.

Decomposition:
- Shared package radio_pkg:
  - FSM state enum: HUNT, LEN, PAYLOAD, CHECK, DELIVER.
  - SYNC_BYTE default.
  - Frame-format constants (data bits 8, stop bits 1).
- One sub-module, radio_byte_rx: synchroniser, bit-timing counter, shift register, byte_valid/frame_err pulses.
  - The transmitter side reuses the same timing constants.

Test Plan:
- Good packet: A5, 03, 11, 22, 33, CHK=03^11^22^33=03 with out_ready=1 → out_data 11, 22, 33 on consecutive cycles, out_last on 33, pkt_ok_count=1, busy low afterwards.
- Backpressure: same packet with out_ready low for 5 cycles at the second byte → out_data holds 22 stable, no byte lost or duplicated.
- Bad checksum: A5, 02, 10, 20, CHK=00 (expected 32) → no out_valid, pkt_err_count=1, next good packet accepted.
- Framing and length errors:
  - Stop bit forced 0 on the payload byte → pkt_err_count increments, back to HUNT.
  - LEN=0 → pkt_err_count increments.
  - LEN=17 → pkt_err_count increments.
- Timeout and glitch:
  - Line idle for 20 bit-times after LEN → error counted.
  - A 3-cycle low pulse on Rx in HUNT → no byte, no count.
- Reset and enable:
  - rst_n asserted mid-payload → all outputs 0 immediately.
  - enable dropped during DELIVER → out_valid low the next cycle, counters unchanged.
  - Counter saturation: 260 bad packets → pkt_err_count=255.

Source files
------------

// File: rtl/radio_pkg.sv
// Shared definitions for the node radio serial link: packet/byte FSM states,
// frame-format constants and a saturating counter helper.
package radio_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DELIVER
  } pkt_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         DATA_BITS         = 8;
  localparam int         STOP_BITS         = 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/radio_byte_rx.sv
// Serial byte receiver: 2-flop synchroniser, mid-bit sampling, LSB-first
// shift register and one-cycle byte_valid / frame_err pulses.
module radio_byte_rx
  import radio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output byte_state_t rx_state
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_MAX   = 3'(DATA_BITS - 1);

  logic          rx_s1, rx_s2, rx_prev;
  byte_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          tick;

  // Flops preset high so the idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_comb tick = (state == B_START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      B_IDLE:  if (rx_prev && !rx_s2) state_next = B_START;
      B_START: if (tick) state_next = rx_s2 ? B_IDLE : B_DATA;
      B_DATA:  if (tick && bit_idx == BIT_MAX) state_next = B_STOP;
      B_STOP:  if (tick) state_next = B_IDLE;
      default: state_next = B_IDLE;
    endcase
    if (!enable) state_next = B_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= B_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == B_IDLE || tick || !enable) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;
      if (state != B_DATA) bit_idx <= '0;
      else if (tick)       bit_idx <= bit_idx + 3'd1;
      if (enable && tick) begin
        if (state == B_DATA) byte_data <= {rx_s2, byte_data[7:1]};
        if (state == B_STOP) begin
          byte_valid <= rx_s2;
          frame_err  <= ~rx_s2;
        end
      end
    end
  end

  assign rx_state = state;

endmodule

// File: rtl/radio_packet_rx.sv
// Packet receiver for the sink: frames SYNC/LEN/payload/CHK, buffers one
// verified payload and streams it to the host, with saturating diagnostics.
module radio_packet_rx
  import radio_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       Rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] pkt_ok_count,
  output logic [7:0] pkt_err_count
);

  localparam int            AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
  localparam int            TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW         = $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYCLES - 1);

  logic [7:0]  byte_data;
  logic        byte_valid, frame_err, byte_active;
  byte_state_t byte_state;
  pkt_state_t  state, state_next;
  logic [7:0]  len, chk, idx, rd_idx;
  logic [7:0]  buf_mem [MAX_LEN];
  logic [TW-1:0] tmo_cnt;
  logic        in_pkt, timeout, pkt_err, pkt_ok;

  radio_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx         (Rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_state   (byte_state)
  );

  always_comb byte_active = (byte_state != B_IDLE);
  always_comb in_pkt      = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
  always_comb timeout     = in_pkt && !byte_active && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_next = state;
    pkt_err    = 1'b0;
    pkt_ok     = 1'b0;
    case (state)
      HUNT: if (byte_valid && byte_data == SYNC_BYTE) state_next = LEN;
      LEN: begin
        if (frame_err || timeout) pkt_err = 1'b1;
        else if (byte_valid) begin
          if (byte_data != 8'd0 && byte_data <= MAX_LEN_B) state_next = PAYLOAD;
          else                                             pkt_err    = 1'b1;
        end
      end
      PAYLOAD: begin
        if (frame_err || timeout)                    pkt_err    = 1'b1;
        else if (byte_valid && idx + 8'd1 == len)    state_next = CHECK;
      end
      CHECK: begin
        if (frame_err || timeout) pkt_err = 1'b1;
        else if (byte_valid) begin
          if (byte_data == chk) begin
            pkt_ok     = 1'b1;
            state_next = DELIVER;
          end else begin
            pkt_err = 1'b1;
          end
        end
      end
      // Bytes arriving while delivering are dropped: the buffer is busy.
      DELIVER: if (out_ready && rd_idx == len - 8'd1) state_next = HUNT;
      default: state_next = HUNT;
    endcase
    if (pkt_err) state_next = HUNT;
    if (!enable) begin
      state_next = HUNT;
      pkt_err    = 1'b0;
      pkt_ok     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len           <= '0;
      chk           <= '0;
      idx           <= '0;
      rd_idx        <= '0;
      tmo_cnt       <= '0;
      pkt_ok_count  <= '0;
      pkt_err_count <= '0;
    end else begin
      if (enable && byte_valid) begin
        if (state == LEN) begin
          len <= byte_data;
          chk <= byte_data;
          idx <= '0;
        end else if (state == PAYLOAD) begin
          chk <= chk ^ byte_data;
          idx <= idx + 8'd1;
        end
      end
      if (state != DELIVER) rd_idx <= '0;
      else if (out_ready)   rd_idx <= rd_idx + 8'd1;
      if (!enable || !in_pkt || byte_active) tmo_cnt <= '0;
      else                                    tmo_cnt <= tmo_cnt + 1'b1;
      if (pkt_ok)  pkt_ok_count  <= sat_inc(pkt_ok_count);
      if (pkt_err) pkt_err_count <= sat_inc(pkt_err_count);
    end
  end

  always_ff @(posedge clk) begin
    if (enable && byte_valid && state == PAYLOAD) buf_mem[idx[AW-1:0]] <= byte_data;
  end

  // Host handshake: out_data/out_last are stable while out_valid is high and
  // out_ready low; a byte transfers on any cycle with out_valid && out_ready.
  always_comb begin
    out_valid = (state == DELIVER);
    out_data  = out_valid ? buf_mem[rd_idx[AW-1:0]] : 8'd0;
    out_last  = out_valid && (rd_idx == len - 8'd1);
    busy      = (state != HUNT);
  end

endmodule

// File: tb/tb_radio_packet_rx.sv
// Bench for radio_packet_rx: packet-level reference model, randomized
// packets, error/timeout/enable/reset scenarios and counter saturation.
module tb_radio_packet_rx;

  localparam int CPB  = 8;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       Rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data, pkt_ok_count, pkt_err_count;
  logic       out_valid, out_last, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_ok  = 0;
  int exp_err = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         got_t[$];
  logic [7:0] pkt_q[$];

  radio_packet_rx #(
    .CLKS_PER_BIT (CPB),
    .MAX_LEN      (MAXL),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .Rx            (Rx),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy),
    .pkt_ok_count  (pkt_ok_count),
    .pkt_err_count (pkt_err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted bytes, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      got_t.push_back(cyc);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_pkt(input int stop_err_at);
    foreach (pkt_q[i]) send_byte(pkt_q[i], i != stop_err_at);
  endtask

  task automatic make_pkt(input int len, input logic bad);
    logic [7:0] x;
    pkt_q = {};
    pkt_q.push_back(8'hA5);
    pkt_q.push_back(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      pkt_q.push_back(8'($urandom_range(0, 255)));
      x = x ^ pkt_q[2 + i];
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    pkt_q.push_back(x);
  endtask

  // Reference: outcome of a whole packet from the framing rules alone.
  task automatic model_pkt(input int stop_err_at);
    int len;
    logic [7:0] x;
    len = int'(pkt_q[1]);
    if (stop_err_at >= 1 || len == 0 || len > MAXL) begin
      exp_err = sat(exp_err);
      return;
    end
    x = pkt_q[1];
    for (int i = 0; i < len; i++) x = x ^ pkt_q[2 + i];
    if (pkt_q[2 + len] != x) begin
      exp_err = sat(exp_err);
    end else begin
      exp_ok = sat(exp_ok);
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pkt_q[2 + i]});
    end
  endtask

  task automatic clear_q();
    got_q = {};
    got_t = {};
    exp_q = {};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b exp 0", out_last); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h exp 00", out_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_tests++; if (pkt_ok_count !== 8'd0) begin n_fail++; $display("FAIL reset_ok: got %0d exp 0", pkt_ok_count); end
    n_tests++; if (pkt_err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d exp 0", pkt_err_count); end
    rst_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    tick(5);
  endtask

  task automatic test_good_packet();
    clear_q();
    pkt_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    model_pkt(-1);
    send_pkt(-1);
    tick(4 * CPB);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL good_count: got %0d bytes exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL good_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < got_t.size(); i++) begin
        n_tests++; if (got_t[i] != got_t[i-1] + 1) begin n_fail++; $display("FAIL good_consec%0d: got cycle %0d exp %0d", i, got_t[i], got_t[i-1] + 1); end
      end
    end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL good_ok: got %0d exp %0d", pkt_ok_count, exp_ok); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b0;
    pkt_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    model_pkt(-1);
    send_pkt(-1);
    tick(2);
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL bp_first: got v=%b d=%h exp v=1 d=11", out_valid, out_data); end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b d=%h exp v=1 d=22", i, out_valid, out_data); end
      tick(1);
    end
    out_ready = 1'b1;
    tick(5);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL bp_ok: got %0d exp %0d", pkt_ok_count, exp_ok); end
  endtask

  task automatic test_bad_checksum();
    clear_q();
    pkt_q = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    model_pkt(-1);
    send_pkt(-1);
    tick(4 * CPB);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL badchk_nodata: got %0d bytes exp 0", got_q.size()); end
    n_tests++; if (pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL badchk_err: got %0d exp %0d", pkt_err_count, exp_err); end
    make_pkt($urandom_range(1, MAXL), 1'b0);
    model_pkt(-1);
    send_pkt(-1);
    tick(4 * CPB);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL badchk_next_count: got %0d bytes exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badchk_next%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL badchk_ok: got %0d exp %0d", pkt_ok_count, exp_ok); end
  endtask

  task automatic test_errors();
    int stop_at;
    for (int c = 0; c < 3; c++) begin
      clear_q();
      case (c)
        0:       begin pkt_q = {8'hA5, 8'h02, 8'h5A}; stop_at = 2; end
        1:       begin pkt_q = {8'hA5, 8'h00};        stop_at = -1; end
        default: begin pkt_q = {8'hA5, 8'd17};        stop_at = -1; end
      endcase
      model_pkt(stop_at);
      send_pkt(stop_at);
      tick(2 * CPB);
      n_tests++; if (pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL err%0d_count: got %0d exp %0d", c, pkt_err_count, exp_err); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err%0d_busy: got %b exp 0", c, busy); end
      n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL err%0d_nodata: got %0d bytes exp 0", c, got_q.size()); end
    end
  endtask

  task automatic test_timeout_glitch();
    clear_q();
    pkt_q = {8'hA5, 8'h03};
    send_pkt(-1);
    tick(CPB * 17);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_before: got busy %b exp 1", busy); end
    tick(CPB * 5);
    exp_err = sat(exp_err);
    n_tests++; if (pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL tmo_err: got %0d exp %0d", pkt_err_count, exp_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b exp 0", busy); end
    Rx = 1'b0;
    tick(3);
    Rx = 1'b1;
    tick(4 * CPB);
    n_tests++; if (pkt_err_count !== 8'(exp_err) || pkt_ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL glitch_counts: got ok=%0d err=%0d exp ok=%0d err=%0d", pkt_ok_count, pkt_err_count, exp_ok, exp_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b exp 0", busy); end
  endtask

  task automatic test_random();
    clear_q();
    for (int p = 0; p < 8; p++) begin
      make_pkt($urandom_range(1, MAXL), $urandom_range(0, 3) == 0);
      model_pkt(-1);
      send_pkt(-1);
    end
    tick(4 * CPB);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d bytes exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL rand_ok: got %0d exp %0d", pkt_ok_count, exp_ok); end
    n_tests++; if (pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL rand_err: got %0d exp %0d", pkt_err_count, exp_err); end
  endtask

  task automatic test_enable();
    clear_q();
    pkt_q = {8'hA5, 8'h04, 8'h01, 8'h02};
    send_pkt(-1);
    enable = 1'b0;
    tick(CPB);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_mid_busy: got %b exp 0", busy); end
    enable = 1'b1;
    tick(CPB);
    n_tests++; if (pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL en_mid_err: got %0d exp %0d", pkt_err_count, exp_err); end
    out_ready = 1'b0;
    make_pkt($urandom_range(1, MAXL), 1'b0);
    model_pkt(-1);
    exp_q = {};
    send_pkt(-1);
    tick(2);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL en_deliver_valid: got %b exp 1", out_valid); end
    enable = 1'b0;
    tick(1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drop_valid: got %b exp 0", out_valid); end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok) || pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL en_counts: got ok=%0d err=%0d exp ok=%0d err=%0d", pkt_ok_count, pkt_err_count, exp_ok, exp_err); end
    enable = 1'b1;
    out_ready = 1'b1;
    tick(4);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL en_discard: got %0d bytes exp 0", got_q.size()); end
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 260; p++) begin
      pkt_q = {8'hA5, 8'h00};
      model_pkt(-1);
      send_pkt(-1);
    end
    tick(CPB);
    n_tests++; if (pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL sat_err: got %0d exp %0d", pkt_err_count, exp_err); end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok)) begin n_fail++; $display("FAIL sat_ok: got %0d exp %0d", pkt_ok_count, exp_ok); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    pkt_q = {8'hA5, 8'h05, 8'h11, 8'h22};
    send_pkt(-1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b exp 1", busy); end
    rst_n = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    #1;
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_outputs: got busy=%b v=%b l=%b d=%h exp all 0", busy, out_valid, out_last, out_data); end
    n_tests++; if (pkt_ok_count !== 8'(exp_ok) || pkt_err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL rstmid_counts: got ok=%0d err=%0d exp 0 0", pkt_ok_count, pkt_err_count); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_backpressure();
    test_bad_checksum();
    test_errors();
    test_timeout_glitch();
    test_random();
    test_enable();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
